// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// FSM state encodings and the per-digit constants used by the datapath.
package bcd_to_bin_seq_pkg;

    // Width of one packed BCD digit.
    localparam int DIGIT_W = 4;

    // Largest legal BCD digit; anything above marks the input invalid.
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    // Reverse double-dabble correction: digits at or above 8 lose 3.
    localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd8;
    localparam logic [DIGIT_W-1:0] ADJ_SUB    = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_to_bin_seq_bcd_digit_adjust.sv
// Single-digit correction step of reverse double-dabble.
// Purely combinational; the subtraction stays within the 4-bit digit.
module bcd_digit_adjust
    import bcd_to_bin_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= ADJ_THRESH) ? (i_digit - ADJ_SUB) : i_digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter. A start pulse captures NDIGITS packed
// BCD digits; BIN_W shift/adjust iterations later the binary value appears
// on o_bin together with a one-cycle o_done pulse. Invalid digits (>9)
// short-circuit to DONE with o_err set and a zero result.
module bcd_to_bin_seq
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int NDIGITS = 2,
    parameter int BIN_W   = 7
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [DIGIT_W*NDIGITS-1:0] i_bcd,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err,
    output logic [BIN_W-1:0]           o_bin
);

    localparam int BCD_W = DIGIT_W * NDIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_t             r_state;
    state_t             w_next;
    logic [BCD_W-1:0]   r_bcd;
    logic [BIN_W-1:0]   r_bin;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    logic [BIN_W-1:0]   r_bin_out;

    logic [BCD_W+BIN_W-1:0] w_shift;
    logic [BCD_W-1:0]       w_bcd_sh;
    logic [BCD_W-1:0]       w_bcd_adj;
    logic [BIN_W-1:0]       w_bin_sh;
    logic                   w_first;
    logic                   w_last;
    logic                   w_bad_any;
    logic                   w_bad;

    // One iteration: shift {bcd, bin} right so the BCD LSB enters the binary MSB.
    assign w_shift  = {r_bcd, r_bin} >> 1;
    assign w_bcd_sh = w_shift[BCD_W+BIN_W-1 -: BCD_W];
    assign w_bin_sh = w_shift[BIN_W-1:0];

    generate
        for (genvar g = 0; g < NDIGITS; g++) begin : g_adj
            bcd_digit_adjust u_adj (
                .i_digit (w_bcd_sh [g*DIGIT_W +: DIGIT_W]),
                .o_digit (w_bcd_adj[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // Counter still at its load value means this is the first SHIFT cycle,
    // the one place where the freshly captured digits are validated.
    assign w_first = (r_cnt == CNT_INIT);
    assign w_last  = (r_cnt == CNT_LAST);
    assign w_bad   = w_first & w_bad_any;

    // Flag any captured digit above 9.
    always_comb begin
        // NOTE: default first, so every path assigns and no latch is inferred.
        w_bad_any = 1'b0;
        for (int d = 0; d < NDIGITS; d++) begin
            if (r_bcd[d*DIGIT_W +: DIGIT_W] > DIGIT_MAX) begin
                w_bad_any = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_next = ST_SHIFT;
            ST_SHIFT: if (w_bad || w_last) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        o_busy = (r_state == ST_SHIFT);
        o_done = (r_state == ST_DONE);
    end

    // Datapath: capture, iterate, and load the result registers on DONE entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bcd     <= '0;
            r_bin     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_bin_out <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_bcd <= i_bcd;
                        r_bin <= '0;
                        r_cnt <= CNT_INIT;
                    end
                end
                ST_SHIFT: begin
                    if (w_bad) begin
                        r_err     <= 1'b1;
                        r_bin_out <= '0;
                    end else begin
                        r_bcd <= w_bcd_adj;
                        r_bin <= w_bin_sh;
                        r_cnt <= r_cnt - CNT_LAST;
                        if (w_last) begin
                            r_bin_out <= w_bin_sh;
                            r_err     <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_err = r_err;
    assign o_bin = r_bin_out;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq (NDIGITS=2, BIN_W=7). Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_bcd_to_bin_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] bcd;
    logic       busy;
    logic       done;
    logic       err;
    logic [6:0] bin;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [6:0] last_bin = 7'd0;
    logic       last_err = 1'b0;

    always #5 clk = ~clk;

    bcd_to_bin_seq #(
        .NDIGITS (2),
        .BIN_W   (7)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_bcd   (bcd),
        .o_busy  (busy),
        .o_done  (done),
        .o_err   (err),
        .o_bin   (bin)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Run one conversion from IDLE. exp_cyc counts cycles from the start
    // edge, cycle 1 being the one right after it. Optionally re-pulse start
    // with a different value while the converter is busy.
    task automatic convert(input string tag, input logic [7:0] v, input logic [6:0] exp_bin,
                           input logic exp_err, input int exp_cyc, input bit poke);
        int cyc;
        int busy_cyc;
        int unstable;
        bit seen;
        bcd   = v;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        bcd      = 8'hEE;
        cyc      = 1;
        busy_cyc = 0;
        unstable = 0;
        seen     = 1'b0;
        while (!seen && cyc <= 20) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cyc++;
                if (bin !== last_bin || err !== last_err) unstable++;
                if (poke && cyc == 3) begin
                    start = 1'b1;
                    bcd   = 8'h17;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, cyc, exp_cyc);
        check({tag, " busy_cycles"}, busy_cyc, exp_cyc - 1);
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        check({tag, " bin"}, 32'(bin), 32'(exp_bin));
        check({tag, " err"}, 32'(err), 32'(exp_err));
        check({tag, " held_between"}, unstable, 0);
        last_bin = exp_bin;
        last_err = exp_err;
        @(negedge clk);
        check({tag, " done_width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int t[3];
        int nd;
        int extra;

        rst   = 1'b1;
        start = 1'b0;
        bcd   = 8'h00;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err",  32'(err),  32'd0);
        check("reset bin",  32'(bin),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        convert("h42", 8'h42, 7'd42, 1'b0, 8, 1'b0);
        convert("h99", 8'h99, 7'd99, 1'b0, 8, 1'b0);
        convert("h00", 8'h00, 7'd0,  1'b0, 8, 1'b0);
        convert("h09", 8'h09, 7'd9,  1'b0, 8, 1'b0);
        convert("h10", 8'h10, 7'd10, 1'b0, 8, 1'b0);
        convert("h5A", 8'h5A, 7'd0,  1'b1, 2, 1'b0);
        convert("hF3", 8'hF3, 7'd0,  1'b1, 2, 1'b0);
        convert("h42_poke", 8'h42, 7'd42, 1'b0, 8, 1'b1);

        // start held high: done pulses must be BIN_W+2 = 9 cycles apart.
        bcd   = 8'h25;
        start = 1'b1;
        nd    = 0;
        for (int c = 0; c < 40 && nd < 3; c++) begin
            @(negedge clk);
            if (done) begin
                t[nd] = c;
                nd++;
            end
        end
        start = 1'b0;
        check("held pulses", nd, 3);
        if (nd == 3) begin
            check("held gap1", t[1] - t[0], 9);
            check("held gap2", t[2] - t[1], 9);
        end
        check("held bin", 32'(bin), 32'd25);
        check("held err", 32'(err), 32'd0);
        last_bin = 7'd25;
        last_err = 1'b0;
        @(negedge clk);

        // Reset during the 4th SHIFT cycle aborts the conversion.
        bcd   = 8'h99;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort bin",  32'(bin),  32'd0);
        rst   = 1'b0;
        extra = 0;
        for (int c = 0; c < 15; c++) begin
            if (done) extra++;
            @(negedge clk);
        end
        check("abort no_done", extra, 0);
        last_bin = 7'd0;
        last_err = 1'b0;

        // All 100 valid two-digit inputs against a decimal model.
        for (int v = 0; v < 100; v++) begin
            logic [7:0] b;
            b = {4'(v / 10), 4'(v % 10)};
            convert($sformatf("sweep%0d", v), b, 7'(v), 1'b0, 8, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
